// File: rtl/knn_pkg.sv
// Shared KNN types: sequencer state encoding, label class count and label type.
// Used by the query sequencer, the vote counter, the input controller and the sorter.
package knn_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int LABEL_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    typedef logic [LABEL_W-1:0] label_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_VOTE   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/knn_vote_counter.sv
// Per-class vote counters with a combinational argmax.
// Ties go to the lowest label index. With KNN_SEQ_TIE_NEAREST_EN defined, the
// label seen at rank 0 (nearest neighbour) is captured and wins any tie it is part of.
module knn_vote_counter
    import knn_pkg::*;
#(
    parameter int K = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   inc,
`ifdef KNN_SEQ_TIE_NEAREST_EN
    input  logic   cap_rank0,
`endif
    input  label_t label,
    output label_t vote_class
);

    // Wide enough to count K votes for a single class, so no overflow is possible.
    localparam int CNT_W = $clog2(K + 1);

    logic [CNT_W-1:0] cnt [NUM_CLASSES];

    // Counters: cleared at the start of each query, bumped once per voted rank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) cnt[c] <= '0;
        end else if (clr) begin
            for (int c = 0; c < NUM_CLASSES; c++) cnt[c] <= '0;
        end else if (inc) begin
            cnt[label] <= cnt[label] + CNT_W'(1);
        end
    end

`ifdef KNN_SEQ_TIE_NEAREST_EN
    label_t rank0_q;

    // Remember the nearest neighbour's label for tie-breaking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rank0_q <= '0;
        end else if (cap_rank0) begin
            rank0_q <= label;
        end
    end
`endif

    label_t           best;
    logic [CNT_W-1:0] best_cnt;

    // Argmax: strict compare keeps the lowest index among equal maxima.
    always_comb begin
        best     = '0;
        best_cnt = cnt[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (cnt[c] > best_cnt) begin
                best     = label_t'(c);
                best_cnt = cnt[c];
            end
        end
`ifdef KNN_SEQ_TIE_NEAREST_EN
        if (cnt[rank0_q] == best_cnt) best = rank0_q;
`endif
        vote_class = best;
    end

endmodule

// File: rtl/knn_query_sequencer.sv
// KNN query sequencer: clears the sorter, streams every stored train point through
// the distance pipeline, drives sorter inserts, then votes over the K nearest labels.
// Optional macro KNN_SEQ_TIE_NEAREST_EN: vote ties favour the rank-0 label.
module knn_query_sequencer
    import knn_pkg::*;
#(
    parameter  int NUM_TRAIN = 128,
    parameter  int DIST_LAT  = 3,
    parameter  int K         = 5,
    localparam int ADDR_W    = $clog2(NUM_TRAIN),
    localparam int SEL_W     = (K > 1) ? $clog2(K) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W:0]   i_num_train,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_sort_clr,
    output logic              o_sort_en,
    output logic [SEL_W-1:0]  o_sel_idx,
    input  label_t            i_sel_label,
    output label_t            o_class,
    output logic              o_valid,
    output logic              o_no_train,
    output logic              o_busy,
    output logic [2:0]        o_current_state
);

    // Memory read plus distance pipeline.
    localparam int PIPE_LAT = DIST_LAT + 1;
    localparam int CNT_W    = ADDR_W + 1;
    localparam int DRN_W    = $clog2(PIPE_LAT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_count(input cnt_t n);
        if (n > cnt_t'(NUM_TRAIN)) return cnt_t'(NUM_TRAIN);
        return n;
    endfunction

    function automatic cnt_t min_k(input cnt_t n);
        if (n > cnt_t'(K)) return cnt_t'(K);
        return n;
    endfunction

    state_t              state;
    state_t              next_state;
    cnt_t                n_q;
    cnt_t                kk_q;
    logic                empty_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DRN_W-1:0]    drain_q;
    logic [SEL_W-1:0]    vsel_q;
    logic [PIPE_LAT-1:0] sort_en_sr;
    label_t              class_q;
    logic                no_train_q;

    cnt_t   n_sat;
    logic   stream_last;
    logic   vote_last;
    logic   rd_en;
    logic   sort_clr;
    logic   busy;
    logic   valid;
    label_t vote_class;
    label_t done_class;

    assign n_sat       = sat_count(i_num_train);
    assign stream_last = ({1'b0, addr_q} == (n_q - cnt_t'(1)));
    assign vote_last   = (cnt_t'(vsel_q) == (kk_q - cnt_t'(1)));
    assign done_class  = empty_q ? label_t'(0) : vote_class;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and strobes; abort overrides every transition.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        sort_clr   = 1'b0;
        busy       = 1'b1;
        valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (i_start) next_state = (n_sat == '0) ? ST_DONE : ST_CLEAR;
            end
            ST_CLEAR: begin
                sort_clr   = 1'b1;
                next_state = ST_STREAM;
            end
            ST_STREAM: begin
                rd_en = 1'b1;
                if (stream_last) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == '0) next_state = ST_VOTE;
            end
            ST_VOTE: begin
                if (vote_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                valid      = !i_abort;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (i_abort) next_state = ST_IDLE;
    end

    // Query parameters, address/drain/rank counters and the sort-enable delay line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q        <= '0;
            kk_q       <= '0;
            empty_q    <= 1'b0;
            addr_q     <= '0;
            drain_q    <= '0;
            vsel_q     <= '0;
            sort_en_sr <= '0;
        end else begin
            if (state == ST_IDLE && i_start && !i_abort) begin
                n_q     <= n_sat;
                kk_q    <= min_k(n_sat);
                empty_q <= (n_sat == '0);
            end
            addr_q  <= (state == ST_STREAM) ? addr_q + ADDR_W'(1) : '0;
            drain_q <= (state == ST_DRAIN) ? drain_q - DRN_W'(1) : DRN_W'(PIPE_LAT - 1);
            vsel_q  <= (state == ST_VOTE) ? vsel_q + SEL_W'(1) : '0;
            // Inserts follow reads by exactly PIPE_LAT cycles; abort drops any in flight.
            if (i_abort) begin
                sort_en_sr <= '0;
            end else begin
                sort_en_sr <= (sort_en_sr << 1) | PIPE_LAT'(rd_en);
            end
        end
    end

    // Result hold registers, loaded on a completed query only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            class_q    <= '0;
            no_train_q <= 1'b0;
        end else if (valid) begin
            class_q    <= done_class;
            no_train_q <= empty_q;
        end
    end

    knn_vote_counter #(
        .K (K)
    ) u_vote (
        .clk        (clk),
        .rst        (rst),
        .clr        (sort_clr),
        .inc        (state == ST_VOTE),
`ifdef KNN_SEQ_TIE_NEAREST_EN
        .cap_rank0  (state == ST_VOTE && vsel_q == '0),
`endif
        .label      (i_sel_label),
        .vote_class (vote_class)
    );

    assign o_rd_en         = rd_en;
    assign o_rd_addr       = addr_q;
    assign o_sort_clr      = sort_clr;
    assign o_sort_en       = sort_en_sr[PIPE_LAT-1];
    assign o_sel_idx       = vsel_q;
    assign o_valid         = valid;
    assign o_class         = valid ? done_class : class_q;
    assign o_no_train      = valid ? empty_q : no_train_q;
    assign o_busy          = busy;
    assign o_current_state = state;

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Directed bench for knn_query_sequencer with a result scoreboard.
// Expected tie result follows KNN_SEQ_TIE_NEAREST_EN.
module tb_knn_query_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_num_train = '0;
    logic       o_rd_en;
    logic [6:0] o_rd_addr;
    logic       o_sort_clr;
    logic       o_sort_en;
    logic [2:0] o_sel_idx;
    logic [1:0] i_sel_label;
    logic [1:0] o_class;
    logic       o_valid;
    logic       o_no_train;
    logic       o_busy;
    logic [2:0] o_current_state;

    logic [1:0] lab_tbl [8];
    assign i_sel_label = lab_tbl[o_sel_idx];

    always #5 clk = ~clk;

    knn_query_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_num_train     (i_num_train),
        .o_rd_en         (o_rd_en),
        .o_rd_addr       (o_rd_addr),
        .o_sort_clr      (o_sort_clr),
        .o_sort_en       (o_sort_en),
        .o_sel_idx       (o_sel_idx),
        .i_sel_label     (i_sel_label),
        .o_class         (o_class),
        .o_valid         (o_valid),
        .o_no_train      (o_no_train),
        .o_busy          (o_busy),
        .o_current_state (o_current_state)
    );

    typedef struct {
        logic [1:0] cls;
        logic       nt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic set_labels(input logic [1:0] a, b, c, d, e);
        for (int i = 0; i < 8; i++) lab_tbl[i] = 2'd0;
        lab_tbl[0] = a; lab_tbl[1] = b; lab_tbl[2] = c; lab_tbl[3] = d; lab_tbl[4] = e;
    endtask

    // One full query: start, watch every cycle until o_valid, then check idle hold.
    task automatic run_query(input string tag, input int n, input int kk,
                             input logic [1:0] cls, input logic nt, input int ign_at);
        int   nsat;
        int   lat;
        int   rd_cnt = 0, se_cnt = 0, clr_cnt = 0, addr_bad = 0, busy_low = 0;
        int   first_rd = -1, first_se = -1, sel_max = -1, valid_e = -1;
        int   extra_v = 0, busy_after = 0;
        bit   done = 0;
        exp_t want;
        nsat = (n > 128) ? 128 : n;
        lat  = (nsat == 0) ? 0 : 1 + nsat + 4 + kk;
        @(negedge clk);
        i_num_train = n[7:0];
        i_start     = 1'b1;
        sb.push_back('{cls, nt});
        for (int e = 0; e < 400 && !done; e++) begin
            @(posedge clk);
            @(negedge clk);
            i_start = (e == ign_at);
            if (o_rd_en) begin
                if (first_rd < 0) first_rd = e;
                if (o_rd_addr !== rd_cnt[6:0]) addr_bad++;
                rd_cnt++;
            end
            if (o_sort_en) begin
                if (first_se < 0) first_se = e;
                se_cnt++;
            end
            if (o_sort_clr) clr_cnt++;
            if (o_current_state == 3'd4 && int'(o_sel_idx) > sel_max) sel_max = int'(o_sel_idx);
            if (o_valid) begin
                valid_e = e;
                done    = 1;
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 1, 0);
                end else begin
                    want = sb.pop_front();
                    chk({tag, "_class"}, o_class, want.cls);
                    chk({tag, "_no_train"}, o_no_train, want.nt);
                end
            end else if (!o_busy) begin
                busy_low++;
            end
        end
        i_start = 1'b0;
        chk({tag, "_got_valid"}, done, 1);
        chk({tag, "_latency"}, valid_e, lat);
        chk({tag, "_rd_count"}, rd_cnt, nsat);
        chk({tag, "_addr_seq"}, addr_bad, 0);
        chk({tag, "_sort_en_count"}, se_cnt, nsat);
        chk({tag, "_sort_clr_count"}, clr_cnt, (nsat > 0) ? 1 : 0);
        chk({tag, "_busy_low"}, busy_low, 0);
        chk({tag, "_sel_max"}, sel_max, (nsat > 0) ? kk - 1 : -1);
        if (nsat > 0) chk({tag, "_sort_en_offset"}, first_se - first_rd, 4);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_valid) extra_v++;
            if (o_busy) busy_after++;
        end
        chk({tag, "_extra_valid"}, extra_v, 0);
        chk({tag, "_busy_after"}, busy_after, 0);
        chk({tag, "_class_held"}, o_class, cls);
        chk({tag, "_no_train_held"}, o_no_train, nt);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tie_cls;
        int         found;
        int         bad_v, bad_se, bad_rd;

        set_labels(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", o_current_state, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_class", o_class, 0);
        chk("rst_no_train", o_no_train, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_sort_en", o_sort_en, 0);
        chk("rst_sort_clr", o_sort_clr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        set_labels(2'd2, 2'd1, 2'd2, 2'd3, 2'd2);
        run_query("full", 128, 5, 2'd2, 1'b0, -1);

        set_labels(2'd1, 2'd3, 2'd3, 2'd2, 2'd2);
        run_query("small", 3, 3, 2'd3, 1'b0, -1);

        run_query("empty", 0, 0, 2'd0, 1'b1, -1);

        set_labels(2'd0, 2'd0, 2'd1, 2'd1, 2'd2);
        run_query("sat", 200, 5, 2'd0, 1'b0, -1);

`ifdef KNN_SEQ_TIE_NEAREST_EN
        tie_cls = 2'd3;
`else
        tie_cls = 2'd1;
`endif
        set_labels(2'd3, 2'd1, 2'd3, 2'd1, 2'd0);
        run_query("tie", 10, 5, tie_cls, 1'b0, -1);

        set_labels(2'd2, 2'd2, 2'd0, 2'd1, 2'd3);
        run_query("start_ignored", 20, 5, 2'd2, 1'b0, 10);

        // Abort at read address 50.
        @(negedge clk);
        i_num_train = 8'd100;
        i_start     = 1'b1;
        sb.push_back('{2'd0, 1'b0});
        @(negedge clk);
        i_start = 1'b0;
        found   = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (o_rd_en && o_rd_addr == 7'd50) found = 1;
            else @(negedge clk);
        end
        chk("abort_reach_addr50", found, 1);
        i_abort = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_state", o_current_state, 0);
        bad_v = 0; bad_se = 0; bad_rd = 0;
        for (int i = 0; i < 150; i++) begin
            if (o_valid) bad_v++;
            if (o_sort_en) bad_se++;
            if (o_rd_en) bad_rd++;
            @(negedge clk);
        end
        chk("abort_no_valid", bad_v, 0);
        chk("abort_no_sort_en", bad_se, 0);
        chk("abort_no_rd_en", bad_rd, 0);
        chk("abort_class_kept", o_class, 2);

        // Start and abort together in IDLE: the start is dropped.
        i_num_train = 8'd5;
        i_start     = 1'b1;
        i_abort     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start_abort_state", o_current_state, 0);
        chk("start_abort_busy", o_busy, 0);
        bad_v = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_valid || o_busy) bad_v++;
        end
        chk("start_abort_quiet", bad_v, 0);

        // Asynchronous reset while voting.
        set_labels(2'd1, 2'd1, 2'd1, 2'd1, 2'd1);
        i_num_train = 8'd10;
        i_start     = 1'b1;
        sb.push_back('{2'd1, 1'b0});
        @(negedge clk);
        i_start = 1'b0;
        found   = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (o_current_state == 3'd4) found = 1;
            else @(negedge clk);
        end
        chk("reset_reach_vote", found, 1);
        #2;
        rst = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("areset_state", o_current_state, 0);
        chk("areset_class", o_class, 0);
        chk("areset_busy", o_busy, 0);
        chk("areset_valid", o_valid, 0);
        chk("areset_sort_en", o_sort_en, 0);
        @(negedge clk);
        rst = 1'b1;
        bad_v = 0; bad_se = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid) bad_v++;
            if (o_sort_en) bad_se++;
        end
        chk("areset_no_valid", bad_v, 0);
        chk("areset_no_sort_en", bad_se, 0);
        chk("areset_class_after", o_class, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/knn_query_sequencer.md
Name: knn_query_sequencer

Overview:
- Sequences one KNN classification query after the test point is loaded and the train memory is filled.
- Streams every stored train point through the distance pipeline and drives the top-K sorter clear/insert strobes.
- Then reads back the K nearest labels, majority-votes them and reports the class.
- Sits between the input controller (which owns memory writes) and the distance/sort datapath.

Parameters:
- NUM_TRAIN, 128, train memory depth; ADDR_W = $clog2(NUM_TRAIN).
- DIST_LAT, 3, distance pipeline latency in cycles. PIPE_LAT = DIST_LAT+1, which includes the 1-cycle memory read.
- K, 5, neighbours voted (1..NUM_TRAIN).
- NUM_CLASSES, 4, label classes; LABEL_W = $clog2(NUM_CLASSES).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- i_start  in  1  query request pulse; honoured only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE.
- i_num_train  in  ADDR_W+1  stored train point count, sampled on accepted i_start.
- o_rd_en  out  1  train memory read enable.
- o_rd_addr  out  ADDR_W  train memory read address.
- o_sort_clr  out  1  clear sorter (one cycle).
- o_sort_en  out  1  insert current distance result into sorter.
- o_sel_idx  out  $clog2(K)  sorter rank selected for readback.
- i_sel_label  in  LABEL_W  label at rank o_sel_idx (combinational, same cycle).
- o_class  out  LABEL_W  voted class, held until next accepted start.
- o_valid  out  1  one-cycle result strobe.
- o_no_train  out  1  query had zero train points; held with o_class.
- o_busy  out  1  high in every state except IDLE.
- o_current_state  out  3  encoded state.

Behaviour:
- Reset: all outputs 0, state IDLE, vote counters 0, sort-enable shift register 0.
- States and encodings: IDLE=0, CLEAR=1, STREAM=2, DRAIN=3, VOTE=4, DONE=5.
- IDLE:
  - i_start with n=i_num_train>0: latch n and kk=min(K,n), go to CLEAR.
  - i_start with n==0: go to DONE with o_class=0 and o_no_train=1.
- CLEAR (1 cycle): o_sort_clr=1, vote counters cleared, go to STREAM.
- STREAM (n cycles): o_rd_en=1, o_rd_addr counts 0..n-1. After address n-1, go to DRAIN.
- DRAIN (PIPE_LAT cycles): o_rd_en=0; a down-counter sets the duration. Go to VOTE.
- o_sort_en: o_rd_en delayed by exactly PIPE_LAT cycles through a shift register. Exactly n pulses per query; the last one falls in the final DRAIN cycle.
- VOTE (kk cycles): o_sel_idx counts 0..kk-1; each cycle increments counter[i_sel_label]. Go to DONE.
- DONE (1 cycle):
  - o_valid=1; o_class=argmax(counters).
  - Default tie-break: lowest label index.
  - Registered o_class/o_no_train update this cycle. Go to IDLE.
- Latency: o_valid is high in the cycle after edge 1+n+PIPE_LAT+kk, counted from the edge sampling i_start. For n==0 it is the next cycle.
- Counter width: $clog2(K+1); the counters cannot overflow.
- i_start while busy: ignored, not queued.
- i_abort in any non-IDLE state:
  - Next state IDLE; shift register flushed.
  - No o_valid; o_class keeps its previous value.
  - i_abort outranks every transition, including DONE.
- Simultaneous i_start and i_abort in IDLE: abort wins and start is dropped.
- Asynchronous reset mid-query: immediate return to reset values. No strobe, no pending sort_en afterwards.
- i_num_train > NUM_TRAIN: saturated to NUM_TRAIN.

Optional Feature:
- Macro: KNN_SEQ_TIE_NEAREST_EN.
- Defined: ties in the vote are broken in favour of the label at rank 0 (the nearest neighbour) when it is among the tied maxima. Otherwise the lowest tied label index wins.
- Undefined: lowest tied label index wins, always. The rank-0 label register is not built.

Decomposition:
- knn_pkg holds:
  - state enum (3-bit, encodings above)
  - NUM_CLASSES, LABEL_W
  - the label typedef, shared with the input controller and sorter.
- Sub-module knn_vote_counter holds:
  - clear/increment counters
  - combinational argmax with tie-break, including the macro-controlled rank-0 capture.
- The sequencer owns the FSM, address counter, drain counter and sort-enable shift register.

Test Plan:
- Full query (defaults): n=128, labels at ranks 0..4 = 2,1,2,3,2.
  - o_rd_addr runs 0..127 contiguously.
  - 128 o_sort_en pulses, the first 4 cycles after the first o_rd_en.
  - o_valid 138 cycles after start; o_class=2; o_busy high throughout.
- Small set: n=3.
  - kk=3, o_sel_idx runs 0..2 only.
  - o_valid at cycle 1+3+4+3=11.
- Empty: n=0.
  - o_valid next cycle with o_no_train=1 and o_class=0.
  - No o_rd_en or o_sort_clr pulses.
- Tie: labels 3,1,3,1,0.
  - Macro off: o_class=1.
  - Macro on: o_class=3.
- Abort in STREAM at address 50, and async reset in VOTE:
  - Both return to IDLE with no o_valid and no further o_sort_en.
  - o_class is unchanged after the abort and 0 after the reset.
- i_start pulsed during STREAM: ignored; exactly one o_valid per accepted query.
